// File: rtl/wb_shared_bus_pkg.sv
// Shared definitions for the 4-master Wishbone shared bus: arbiter states,
// master count and master-index types, used by the arbiter, bus mux and bench.
package wb_shared_bus_pkg;

    localparam int NUM_M   = 4;
    localparam int M_IDX_W = 2;

    typedef logic [M_IDX_W-1:0] m_idx_t;
    typedef logic [NUM_M-1:0]   m_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_TOERR = 2'd2
    } arb_state_t;

    function automatic m_vec_t idx_to_onehot(input m_idx_t idx);
        m_vec_t vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational 4-way round-robin picker: searches last+1, last+2, last+3, last
// (mod 4) among the unmasked requests and returns the first hit.
module wb_rr_pick
    import wb_shared_bus_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic [3:0] mask,
    output logic       valid,
    output logic [3:0] pick,
    output logic [1:0] pick_id
);

    logic [3:0] cand;
    logic [1:0] order_id [4];
    logic [3:0] order_hit;

    assign cand = req & ~mask;

    // Position gi in the search order is master last+gi+1, wrapping naturally in 2 bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_order
            assign order_id[gi]  = last + 2'(gi + 1);
            assign order_hit[gi] = cand[order_id[gi]];
        end
    endgenerate

    always_comb begin
        valid   = 1'b0;
        pick_id = last;
        for (int i = 3; i >= 0; i--) begin
            if (order_hit[i]) begin
                valid   = 1'b1;
                pick_id = order_id[i];
            end
        end
    end

    assign pick = valid ? idx_to_onehot(pick_id) : 4'b0000;

endmodule

// File: rtl/wb_shared_bus_arb.sv
// Round-robin bus arbiter with a stalled-transfer watchdog for the 4-master
// Wishbone shared bus. Grants are held for the whole CYC, never preempted.
module wb_shared_bus_arb #(
    parameter int NUM_M     = 4,
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] m_cyc,
    input  logic [NUM_M-1:0] m_stb,
    input  logic             s_ack,
    input  logic             s_err,
    input  logic             s_rty,
    input  logic             to_clr,
    output logic [NUM_M-1:0] gnt,
    output logic [1:0]       gnt_id,
    output logic             busy,
    output logic             to_err,
    output logic             to_flag,
    output logic [1:0]       to_id
);
    import wb_shared_bus_pkg::*;

    localparam logic [TO_W-1:0] WD_FIRE = TO_W'(TO_CYCLES - 1);
    localparam logic [TO_W-1:0] WD_MAX  = TO_W'(TO_CYCLES);

    arb_state_t       state_reg;
    logic [3:0]       gnt_reg;
    logic [1:0]       gnt_id_reg;
    logic [1:0]       last_reg;
    logic             busy_reg;
    logic             to_err_reg;
    logic             to_flag_reg;
    logic [1:0]       to_id_reg;
    logic [TO_W-1:0]  wd_reg;

    logic             pick_valid;
    logic [3:0]       pick_vec;
    logic [1:0]       pick_id;
    logic             owner_cyc;
    logic             owner_stb;
    logic             term;
    logic             stall;

    assign owner_cyc = m_cyc[gnt_id_reg];
    assign owner_stb = m_stb[gnt_id_reg];
    assign term      = s_ack | s_err | s_rty;
    assign stall     = owner_stb & ~term;

    // Masking with the current grant excludes the owner on handover; in IDLE the
    // grant is zero so every requester is a candidate.
    wb_rr_pick u_pick (
        .req     (m_cyc),
        .last    (last_reg),
        .mask    (gnt_reg),
        .valid   (pick_valid),
        .pick    (pick_vec),
        .pick_id (pick_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            last_reg    <= 2'd3;
            busy_reg    <= 1'b0;
            to_err_reg  <= 1'b0;
            to_flag_reg <= 1'b0;
            to_id_reg   <= '0;
            wd_reg      <= '0;
        end else begin
            to_err_reg <= 1'b0;
            if (to_clr) begin
                to_flag_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg  <= ST_BUSY;
                        gnt_reg    <= pick_vec;
                        gnt_id_reg <= pick_id;
                        last_reg   <= pick_id;
                        busy_reg   <= 1'b1;
                        wd_reg     <= '0;
                    end
                end

                ST_BUSY: begin
                    if (!owner_cyc) begin
                        wd_reg <= '0;
                        if (pick_valid) begin
                            gnt_reg    <= pick_vec;
                            gnt_id_reg <= pick_id;
                            last_reg   <= pick_id;
                        end else begin
                            state_reg <= ST_IDLE;
                            gnt_reg   <= '0;
                            busy_reg  <= 1'b0;
                        end
                    end else if (!stall) begin
                        wd_reg <= '0;
                    end else if (wd_reg == WD_FIRE) begin
                        state_reg  <= ST_TOERR;
                        to_err_reg <= 1'b1;
                    end else if (wd_reg != WD_MAX) begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end

                ST_TOERR: begin
                    // Written after the to_clr default so a coincident fire wins.
                    to_flag_reg <= 1'b1;
                    to_id_reg   <= gnt_id_reg;
                    wd_reg      <= '0;
                    state_reg   <= ST_BUSY;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = busy_reg;
    assign to_err  = to_err_reg;
    assign to_flag = to_flag_reg;
    assign to_id   = to_id_reg;

endmodule

// File: tb/tb_wb_shared_bus_arb.sv
// Directed bench for wb_shared_bus_arb: grant, round-robin handover, no
// preemption, watchdog fire/clear, ACK refresh and asynchronous reset.
module tb_wb_shared_bus_arb;
    import wb_shared_bus_pkg::*;

    localparam int TO_CYC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] m_cyc;
    logic [3:0] m_stb;
    logic       s_ack;
    logic       s_err;
    logic       s_rty;
    logic       to_clr;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       to_err;
    logic       to_flag;
    logic [1:0] to_id;

    int errors = 0;
    int checks = 0;

    wb_shared_bus_arb #(
        .NUM_M     (4),
        .TO_CYCLES (TO_CYC),
        .TO_W      (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .s_rty   (s_rty),
        .to_clr  (to_clr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .to_err  (to_err),
        .to_flag (to_flag),
        .to_id   (to_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_vec_t     exp_vec;
        logic [1:0] exp_id;
        int         fires;

        rst    = 1'b1;
        m_cyc  = '0;
        m_stb  = '0;
        s_ack  = 1'b0;
        s_err  = 1'b0;
        s_rty  = 1'b0;
        to_clr = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_gnt_id", gnt_id, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_to_err", to_err, 1'b0);
        check("rst_to_flag", to_flag, 1'b0);
        check("rst_to_id", to_id, 2'd0);
        rst = 1'b1;
        tick();
        $display("reset: gnt=%b busy=%b", gnt, busy);

        // Single request from master 2
        m_cyc = 4'b0100;
        tick();
        check("single_gnt", gnt, 4'b0100);
        check("single_id", gnt_id, 2'd2);
        check("single_busy", busy, 1'b1);
        $display("single grant: gnt=%b id=%0d", gnt, gnt_id);
        m_cyc = 4'b0000;
        tick();
        check("single_rel_gnt", gnt, 4'b0000);
        check("single_rel_busy", busy, 1'b0);
        check("single_rel_id_hold", gnt_id, 2'd2);
        $display("single release: gnt=%b id=%0d", gnt, gnt_id);

        // Re-reset so the round-robin pointer starts at 3 and master 0 wins first
        rst = 1'b0;
        tick();
        rst = 1'b1;

        // All four request; each owner keeps CYC for 3 cycles then drops it
        m_cyc  = 4'b1111;
        exp_id = 2'd0;
        tick();
        for (int n = 0; n < 5; n++) begin
            exp_vec = idx_to_onehot(exp_id);
            check("rr_gnt", gnt, exp_vec);
            check("rr_id", gnt_id, exp_id);
            $display("round-robin grant %0d: gnt=%b id=%0d", n, gnt, gnt_id);
            for (int c = 0; c < 3; c++) begin
                tick();
                check("rr_hold", gnt, exp_vec);
            end
            m_cyc = (n < 4) ? (4'b1111 & ~exp_vec) : 4'b0000;
            tick();
            if (n < 4) m_cyc = 4'b1111;
            exp_id = exp_id + 2'd1;
        end
        check("rr_end_gnt", gnt, 4'b0000);
        check("rr_end_busy", busy, 1'b0);

        // No preemption: master 2 owns while master 0 requests
        m_cyc = 4'b0100;
        tick();
        check("nopre_gnt", gnt, 4'b0100);
        m_cyc = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("nopre_hold", gnt, 4'b0100);
        end
        m_cyc = 4'b0001;
        tick();
        check("nopre_handover", gnt, 4'b0001);
        check("nopre_handover_id", gnt_id, 2'd0);
        check("nopre_busy", busy, 1'b1);
        $display("no-preemption handover: gnt=%b id=%0d", gnt, gnt_id);
        m_cyc = 4'b0000;
        tick();
        check("nopre_rel", gnt, 4'b0000);

        // Watchdog: master 1 stalls with STB high and no termination
        m_cyc = 4'b0010;
        m_stb = 4'b0010;
        tick();
        check("wd_gnt", gnt, 4'b0010);
        check("wd_to_err_g", to_err, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            check("wd_to_err", to_err, (k == TO_CYC || k == 2 * TO_CYC + 1) ? 1'b1 : 1'b0);
            check("wd_to_flag", to_flag, (k == TO_CYC + 1 || k == 2 * TO_CYC + 2) ? 1'b1 : 1'b0);
            if (k == TO_CYC + 1 || k == 2 * TO_CYC + 2) begin
                check("wd_to_id", to_id, 2'd1);
                $display("watchdog event at G+%0d: to_flag=%b to_id=%0d", k - 1, to_flag, to_id);
            end
            // Clear in a plain BUSY cycle, then again on the TOERR cycle where the fire must win
            to_clr = (k == TO_CYC + 1 || k == 2 * TO_CYC + 1);
        end
        to_clr = 1'b0;
        m_cyc  = 4'b0000;
        m_stb  = 4'b0000;
        tick();
        check("wd_rel", gnt, 4'b0000);

        // ACK every 5 cycles keeps the watchdog from firing
        m_cyc  = 4'b0010;
        m_stb  = 4'b0010;
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        check("ack_gnt", gnt, 4'b0010);
        check("ack_flag_clr", to_flag, 1'b0);
        fires = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (to_err) fires++;
            s_ack = (k % 5 == 0);
        end
        s_ack = 1'b0;
        check("ack_no_fire", fires, 0);
        check("ack_no_flag", to_flag, 1'b0);
        check("ack_still_owner", gnt, 4'b0010);
        $display("ack refresh: fires=%0d over 100 cycles", fires);

        // Asynchronous reset between clock edges while master 1 owns the bus
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_gnt", gnt, 4'b0000);
        check("arst_busy", busy, 1'b0);
        check("arst_id", gnt_id, 2'd0);
        m_cyc = 4'b0000;
        m_stb = 4'b0000;
        tick();
        rst   = 1'b1;
        m_cyc = 4'b1000;
        tick();
        check("arst_after_gnt", gnt, 4'b1000);
        check("arst_after_id", gnt_id, 2'd3);
        $display("after async reset: gnt=%b id=%0d", gnt, gnt_id);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
